// File: rtl/rrf_allocator.sv
// Rename register file tag allocator: circular alloc/commit pointers
// with a free-entry count, all-or-nothing dual grant and flush recovery.
module rrf_allocator #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               dp_req1_i,
  input  logic               dp_req2_i,
  input  logic               dp_hold_i,
  input  logic               com_free1_i,
  input  logic               com_free2_i,
  input  logic               flush_i,
  output logic               alloc_en1_o,
  output logic               alloc_en2_o,
  output logic [RRF_SEL-1:0] alloc_tag1_o,
  output logic [RRF_SEL-1:0] alloc_tag2_o,
  output logic [RRF_SEL-1:0] com_tag1_o,
  output logic [RRF_SEL-1:0] com_tag2_o,
  output logic               stall_o,
  output logic [RRF_SEL:0]   free_num_o,
  output logic               empty_o,
  output logic               err_o
);

  localparam logic [RRF_SEL:0] NUM = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] alloc_ptr;
  logic [RRF_SEL-1:0] com_ptr;
  logic [RRF_SEL:0]   free_num;
  logic               err;

  logic [1:0]         need;
  logic [1:0]         com_req;
  logic [1:0]         com_cnt;
  logic [1:0]         take;
  logic [RRF_SEL:0]   used;
  logic               over;
  logic               grant;
  logic [RRF_SEL-1:0] com_next;

  assign need    = {1'b0, dp_req1_i} + {1'b0, dp_req2_i};
  assign com_req = {1'b0, com_free1_i} + {1'b0, com_free2_i};

  // stall looks only at the registered count; same-cycle frees wait
  assign stall_o = ((RRF_SEL+1)'(need) > free_num) | flush_i;
  assign grant   = (need != 2'd0) & ~stall_o & ~dp_hold_i;
  assign take    = grant ? need : 2'd0;

  assign alloc_en1_o  = grant & dp_req1_i;
  assign alloc_en2_o  = grant & dp_req2_i;
  assign alloc_tag1_o = alloc_ptr;
  assign alloc_tag2_o = alloc_ptr + RRF_SEL'(dp_req1_i);

  assign com_tag1_o = com_ptr;
  assign com_tag2_o = com_ptr + RRF_SEL'(1);

  // commits are clamped to the number of live entries
  assign used     = NUM - free_num;
  assign over     = (RRF_SEL+1)'(com_req) > used;
  assign com_cnt  = over ? used[1:0] : com_req;
  assign com_next = com_ptr + RRF_SEL'(com_cnt);

  assign free_num_o = free_num;
  assign empty_o    = (free_num == '0);
  assign err_o      = err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alloc_ptr <= '0;
      com_ptr   <= '0;
      free_num  <= NUM;
      err       <= 1'b0;
    end else begin
      if (over)
        err <= 1'b1;
      com_ptr <= com_next;
      if (flush_i) begin
        alloc_ptr <= com_next;
        free_num  <= NUM;
      end else begin
        alloc_ptr <= alloc_ptr + RRF_SEL'(take);
        free_num  <= free_num - (RRF_SEL+1)'(take)
                   + (RRF_SEL+1)'(com_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rrf_allocator.sv
// Bench for rrf_allocator: occupancy model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_rrf_allocator;

  localparam int N = 64;
  localparam int S = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r1 = 0, r2 = 0, hold = 0, c1 = 0, c2 = 0, fl = 0;
  logic en1, en2, stall, empty, err;
  logic [S-1:0] tag1, tag2, ctag1, ctag2;
  logic [S:0] free;

  int n_chk = 0;
  int n_fail = 0;

  rrf_allocator #(.RRF_NUM(N), .RRF_SEL(S)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dp_req1_i(r1), .dp_req2_i(r2), .dp_hold_i(hold),
    .com_free1_i(c1), .com_free2_i(c2), .flush_i(fl),
    .alloc_en1_o(en1), .alloc_en2_o(en2),
    .alloc_tag1_o(tag1), .alloc_tag2_o(tag2),
    .com_tag1_o(ctag1), .com_tag2_o(ctag2),
    .stall_o(stall), .free_num_o(free),
    .empty_o(empty), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: next tag to hand out, oldest live tag, live count
  int m_next = 0;
  int m_old = 0;
  int m_live = 0;
  bit m_err = 0;

  function automatic int m_need();
    return int'(r1) + int'(r2);
  endfunction

  function automatic bit m_grant();
    int fr;
    fr = N - m_live;
    return m_need() != 0 && m_need() <= fr && !fl && !hold;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_free", int'(free), N - m_live);
      chk("m_empty", int'(empty), int'(m_live == N));
      chk("m_err", int'(err), int'(m_err));
      chk("m_stall", int'(stall), int'(fl || m_need() > N - m_live));
      chk("m_en1", int'(en1), int'(m_grant() && r1));
      chk("m_en2", int'(en2), int'(m_grant() && r2));
      if (en1) chk("m_tag1", int'(tag1), m_next);
      if (en2) chk("m_tag2", int'(tag2), (m_next + int'(r1)) % N);
      chk("m_ctag1", int'(ctag1), m_old);
      chk("m_ctag2", int'(ctag2), (m_old + 1) % N);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    int req, cnt;
    if (!rst_n) begin
      m_next = 0; m_old = 0; m_live = 0; m_err = 0;
    end else begin
      req = int'(c1) + int'(c2);
      cnt = (req > m_live) ? m_live : req;
      if (req > m_live) m_err = 1;
      if (fl) begin
        m_old = (m_old + cnt) % N;
        m_next = m_old;
        m_live = 0;
      end else begin
        if (m_grant()) begin
          m_next = (m_next + m_need()) % N;
          m_live += m_need();
        end
        m_old = (m_old + cnt) % N;
        m_live -= cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_free", int'(free), 64);
    chk("rst_empty", int'(empty), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_en", int'(en1 | en2), 0);

    // dual allocation from reset
    r1 = 1; r2 = 1; #1;
    chk("dual_en", int'({en1, en2}), 3);
    chk("dual_tag1", int'(tag1), 0);
    chk("dual_tag2", int'(tag2), 1);
    step();
    chk("dual_free", int'(free), 62);
    chk("dual_tag3", int'(tag1), 2);
    chk("dual_tag4", int'(tag2), 3);

    // fill
    repeat (31) step();
    r2 = 0; #1;
    chk("fill_free", int'(free), 0);
    chk("fill_empty", int'(empty), 1);
    chk("fill_stall", int'(stall), 1);
    chk("fill_en", int'(en1), 0);
    c1 = 1;
    step();
    c1 = 0; #1;
    chk("free1_free", int'(free), 1);
    chk("free1_en", int'(en1), 1);
    chk("free1_tag", int'(tag1), 0);
    step();
    r1 = 0; c1 = 1;
    step();
    c1 = 0;

    // dual request and dual commit with one free entry
    r1 = 1; r2 = 1; c1 = 1; c2 = 1; #1;
    chk("sim_free", int'(free), 1);
    chk("sim_stall", int'(stall), 1);
    chk("sim_en", int'(en1 | en2), 0);
    step();
    c1 = 0; c2 = 0; #1;
    chk("sim_free3", int'(free), 3);
    chk("sim_grant", int'({en1, en2}), 3);
    chk("sim_tag1", int'(tag1), 1);
    chk("sim_tag2", int'(tag2), 2);
    step();
    r1 = 0; r2 = 0;

    // hold blocks allocation without stalling
    r1 = 1; hold = 1; #1;
    chk("hold_en", int'(en1), 0);
    chk("hold_stall", int'(stall), 0);
    step();
    hold = 0; r1 = 0; #1;
    chk("hold_free", int'(free), 1);

    // flush with 10 allocated
    rst_n = 0; #2 rst_n = 1;
    r1 = 1; r2 = 1;
    repeat (5) step();
    r1 = 0; r2 = 0; #1;
    chk("pre_fl_free", int'(free), 54);
    fl = 1; c1 = 1; r1 = 1; #1;
    chk("fl_stall", int'(stall), 1);
    chk("fl_en", int'(en1), 0);
    step();
    fl = 0; c1 = 0; #1;
    chk("fl_free", int'(free), 64);
    chk("fl_en1", int'(en1), 1);
    chk("fl_tag", int'(tag1), 1);
    r1 = 0;

    // commit overflow
    c1 = 1;
    step();
    c1 = 0; #1;
    chk("ovf_err", int'(err), 1);
    chk("ovf_free", int'(free), 64);

    // reset mid-stream, between edges
    r1 = 1; r2 = 1;
    step();
    step();
    #3;
    rst_n = 0; r1 = 0; r2 = 0; #1;
    chk("ar_free", int'(free), 64);
    chk("ar_empty", int'(empty), 0);
    chk("ar_err", int'(err), 0);
    chk("ar_stall", int'(stall), 0);
    chk("ar_en", int'(en1 | en2), 0);
    chk("ar_ctag", int'(ctag1), 0);
    step();
    rst_n = 1;

    // wrap-around of a dual grant
    r1 = 1;
    step();
    r2 = 1;
    repeat (31) step();
    r1 = 0; r2 = 0; c1 = 1;
    step();
    c1 = 0;
    r1 = 1; r2 = 1; #1;
    chk("wrap_en", int'({en1, en2}), 3);
    chk("wrap_tag1", int'(tag1), 63);
    chk("wrap_tag2", int'(tag2), 0);
    step();
    r1 = 0; r2 = 0; #1;
    chk("wrap_free", int'(free), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rrf_allocator.md
RRF_ALLOCATOR -- requirements
Module: rrf_allocator

Interface
REQ-001 SHALL have parameter RRF_NUM, default 64, the number of rename register entries; it SHALL be a power of two.
REQ-002 SHALL have parameter RRF_SEL, default 6, the tag width; it SHALL equal log2(RRF_NUM).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports dp_req1_i and dp_req2_i, input, 1 bit each: dispatch slots 1 and 2 each need one destination tag this cycle.
REQ-006 SHALL have port dp_hold_i, input, 1 bit: downstream dispatch stall; no allocation occurs while it is high.
REQ-007 SHALL have ports com_free1_i and com_free2_i, input, 1 bit each: the commit stage retires the oldest one or two allocated entries.
REQ-008 SHALL have port flush_i, input, 1 bit: misprediction recovery; releases every entry that has not been committed.
REQ-009 SHALL have ports alloc_en1_o/alloc_en2_o, output, 1 bit each, and alloc_tag1_o/alloc_tag2_o, output, RRF_SEL bits each: the granted allocations and their tags, which drive the rename file allocate port.
REQ-010 SHALL have ports com_tag1_o and com_tag2_o, output, RRF_SEL bits each: the tags being retired, which drive the completed-tag read of the rename file.
REQ-011 SHALL have port stall_o, output, 1 bit: the dispatch request cannot be granted this cycle.
REQ-012 SHALL have port free_num_o, output, RRF_SEL+1 bits: the current number of free entries.
REQ-013 SHALL have ports empty_o and err_o, output, 1 bit each: empty_o means no free entry; err_o is a sticky commit-overflow error.

Function
REQ-014 SHALL keep registered state alloc_ptr (RRF_SEL bits), com_ptr (RRF_SEL bits), free_num (0..RRF_NUM) and err; both pointers SHALL wrap modulo RRF_NUM.
REQ-015 SHALL define need = dp_req1_i + dp_req2_i, and SHALL drive stall_o = (need > free_num) OR flush_i, combinationally.
REQ-016 SHALL define grant = (need != 0) AND NOT stall_o AND NOT dp_hold_i; a grant SHALL be all-or-nothing, with no partial grant.
REQ-017 SHALL drive, on grant: alloc_tag1_o = alloc_ptr, alloc_en1_o = dp_req1_i, alloc_tag2_o = alloc_ptr + dp_req1_i, alloc_en2_o = dp_req2_i; these outputs are combinational with zero latency, and both enables SHALL be 0 without a grant.
REQ-018 SHALL advance alloc_ptr by need at the next edge after a grant.
REQ-019 SHALL define com_req = com_free1_i + com_free2_i (com_free2_i alone counts as 1), and SHALL drive com_tag1_o = com_ptr and com_tag2_o = com_ptr + 1 at all times.
REQ-020 SHALL clamp commits: com_cnt = min(com_req, RRF_NUM - free_num); if com_req exceeds that limit, err SHALL be set and SHALL stay set until reset.
REQ-021 SHALL advance com_ptr by com_cnt.
REQ-022 SHALL update free_num_next = free_num - (grant ? need : 0) + com_cnt when the cycle has no flush.
REQ-023 SHALL base stall on the registered free_num only, so entries freed in a cycle become allocatable the following cycle.
REQ-024 SHALL give flush_i priority over allocation; the same-cycle commit is still honored.
REQ-025 SHALL set, on a flush, com_ptr <= com_ptr + com_cnt, alloc_ptr <= the same value, and free_num <= RRF_NUM.
REQ-026 SHALL drive empty_o = (free_num == 0), free_num_o = free_num and err_o = err, all from registers.
REQ-027 SHALL treat tag wrap-around as ordinary: with alloc_ptr = RRF_NUM-1 and a dual grant, the tags SHALL be RRF_NUM-1 and 0.

Reset
REQ-028 SHALL, while reset_n_i is low, asynchronously set alloc_ptr = 0, com_ptr = 0, free_num = RRF_NUM and err = 0; outputs SHALL then read free_num_o = 64, empty_o = 0, err_o = 0, stall_o = 0 and no grants.
REQ-029 SHALL abort any operation when reset is asserted mid-operation, with no pending state surviving.
REQ-030 SHALL resume normal operation at the first rising edge after reset_n_i deasserts.

Verification
REQ-031 Dual allocation after reset: req1 = req2 = 1 -> tags 0 and 1 with both enables high; the next cycle free_num_o = 62 and the next tags are 2 and 3.
REQ-032 Fill: 32 dual grants -> free_num_o = 0, empty_o = 1; a single req1 is then stalled (stall_o = 1, no enable); one commit (com_free1_i) -> the next cycle free_num_o = 1 and req1 is granted tag 0.
REQ-033 Simultaneous events: with free_num = 1, a dual request plus a dual commit -> stall_o = 1 that cycle; the next cycle free_num_o = 3 and a dual request is granted.
REQ-034 Flush: with 10 entries allocated and com_ptr = 0, flush_i plus com_free1_i -> no grant; the next cycle free_num_o = 64 and the next allocation tag is 1.
REQ-035 Overflow and reset: com_free1_i asserted with free_num = 64 -> err_o = 1 and free_num_o stays 64; asserting reset_n_i low mid-stream -> all outputs return to the REQ-028 values without waiting for a clock edge.
